n64_response_assembler: RTL and testbench

N64_RESPONSE_ASSEMBLER -- requirements
Module: n64_response_assembler

---
 rtl/n64_response_assembler.sv | 162 ++++++++++++++++
 tb/tb_n64_response_assembler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_response_assembler.sv
`default_nettype none
// ============================================================================
// Module      : n64_response_assembler
// Description : APB3 slave that assembles decoded N64 controller response
//               bits into frames, with timeout/overrun flags and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_response_assembler #(
    parameter int unsigned FRAME_BITS     = 32,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd10000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        bit_valid,
    input  logic        bit_data,
    output logic        frame_irq
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    localparam logic [7:0] c_OFF_CTRL   = 8'h00;
    localparam logic [7:0] c_OFF_STATUS = 8'h04;
    localparam logic [7:0] c_OFF_DATA   = 8'h08;
    localparam logic [7:0] c_OFF_COUNT  = 8'h0C;

    localparam logic [5:0] c_FRAME_BITS = 6'(FRAME_BITS);

    logic [1:0]            r_state;
    logic                  r_irq_en;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_overrun;
    logic                  r_irq;
    logic [5:0]            r_count;
    logic [15:0]           r_timer;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_data;
    logic [15:0]           r_frame_count;

    logic [7:0]            w_off;
    logic                  w_sel_ctrl;
    logic                  w_sel_status;
    logic                  w_sel_data;
    logic                  w_sel_count;
    logic                  w_off_valid;
    logic                  w_wr;
    logic                  w_arm;
    logic                  w_stat_wr;
    logic [5:0]            w_count_inc;
    logic [15:0]           w_timer_inc;
    logic [FRAME_BITS:0]   w_shift_wide;
    logic [FRAME_BITS-1:0] w_shift_next;
    logic [63:0]           w_data_ext;
    logic [31:0]           w_status;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_off        = PADDR[7:0];
    assign w_sel_ctrl   = (w_off == c_OFF_CTRL);
    assign w_sel_status = (w_off == c_OFF_STATUS);
    assign w_sel_data   = (w_off == c_OFF_DATA);
    assign w_sel_count  = (w_off == c_OFF_COUNT);
    assign w_off_valid  = w_sel_ctrl | w_sel_status | w_sel_data | w_sel_count;

    // Writes to undecoded offsets are dropped by qualifying with w_off_valid.
    assign w_wr      = PSEL & PENABLE & PWRITE & w_off_valid;
    assign w_arm     = w_wr & w_sel_ctrl & PWDATA[0];
    assign w_stat_wr = w_wr & w_sel_status;

    assign w_count_inc  = r_count + 6'd1;
    assign w_timer_inc  = r_timer + 16'd1;
    // Widened concatenation keeps the shift legal for a 1-bit frame.
    assign w_shift_wide = {r_shift, bit_data};
    assign w_shift_next = w_shift_wide[FRAME_BITS-1:0];
    assign w_data_ext   = 64'(r_data);

    assign w_status = {18'd0, r_count, 4'd0, r_overrun, r_timeout, r_done,
                       (r_state == c_ST_COLLECT)};

    always_comb begin
        w_rdata = 32'd0;
        if (w_sel_ctrl)   w_rdata = {30'd0, r_irq_en, 1'b0};
        if (w_sel_status) w_rdata = w_status;
        if (w_sel_data)   w_rdata = w_data_ext[31:0];
        if (w_sel_count)  w_rdata = {16'd0, r_frame_count};
    end

    assign PREADY    = 1'b1;
    assign PRDATA    = (PSEL & ~PWRITE) ? w_rdata : 32'd0;
    assign PSLVERR   = PRESERN & PSEL & PENABLE & ~w_off_valid;
    assign frame_irq = r_irq;

    assign w_unused = ^{PADDR[31:8], PWDATA[31:4], w_data_ext[63:32]};

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state       <= c_ST_IDLE;
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_overrun     <= 1'b0;
            r_irq         <= 1'b0;
            r_count       <= 6'd0;
            r_timer       <= 16'd0;
            r_shift       <= '0;
            r_data        <= '0;
            r_frame_count <= 16'd0;
        end else begin
            if (w_wr && w_sel_ctrl) r_irq_en <= PWDATA[1];
            r_irq <= r_irq_en & (r_done | r_timeout);

            // Clears come first so a same-cycle hardware set below wins.
            if (w_stat_wr && PWDATA[1]) r_done    <= 1'b0;
            if (w_stat_wr && PWDATA[2]) r_timeout <= 1'b0;
            if (w_stat_wr && PWDATA[3]) r_overrun <= 1'b0;

            if (w_arm) begin
                r_state <= c_ST_COLLECT;
                r_shift <= '0;
                r_count <= 6'd0;
                r_timer <= 16'd0;
            end else begin
                case (r_state)
                    c_ST_COLLECT: begin
                        if (bit_valid) begin
                            r_shift <= w_shift_next;
                            r_count <= w_count_inc;
                            r_timer <= 16'd0;
                            if (w_count_inc == c_FRAME_BITS) begin
                                r_data        <= w_shift_next;
                                r_done        <= 1'b1;
                                r_frame_count <= r_frame_count + 16'd1;
                                r_state       <= c_ST_DONE;
                            end
                        end else if (w_timer_inc == TIMEOUT_CYCLES) begin
                            r_timeout <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    c_ST_DONE: begin
                        if (bit_valid) r_overrun <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_n64_response_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_n64_response_assembler
// Description : Randomised scoreboard bench for n64_response_assembler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_response_assembler;

    localparam int c_FB = 32;
    localparam int c_TO = 40;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = 32'd0, PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        bit_valid = 1'b0, bit_data = 1'b0;
    logic        frame_irq;

    n64_response_assembler #(
        .FRAME_BITS     (c_FB),
        .TIMEOUT_CYCLES (16'(c_TO))
    ) dut (
        .PCLK      (PCLK),
        .PRESERN   (PRESERN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .frame_irq (frame_irq)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = not collecting, 1 = collecting, 2 = frame held
    int          m_mode;
    bit          m_q[$];
    logic [63:0] m_data;
    logic [15:0] m_fc;
    bit          m_irq_en, m_done, m_timeout, m_overrun;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] rd;
        logic        err;
        logic        irq;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_data = '0; m_fc = '0;
        m_irq_en = 0; m_done = 0; m_timeout = 0; m_overrun = 0;
    endtask

    task automatic model_bit(input bit b);
        if (m_mode == 1) begin
            m_q.push_back(b);
            if (m_q.size() == c_FB) begin
                m_data = '0;
                foreach (m_q[i]) m_data = (m_data << 1) | 64'(m_q[i]);
                m_done = 1; m_fc = m_fc + 16'd1; m_mode = 2;
            end
        end else if (m_mode == 2) begin
            m_overrun = 1;
        end
    endtask

    task automatic model_timeout();
        if (m_mode == 1) begin m_timeout = 1; m_mode = 0; end
    endtask

    function automatic logic [31:0] exp_rd(input logic [7:0] a);
        case (a)
            8'h00: return {30'd0, m_irq_en, 1'b0};
            8'h04: return (32'(m_q.size()) << 8) | (32'(m_overrun) << 3) |
                          (32'(m_timeout) << 2) | (32'(m_done) << 1) | 32'(m_mode == 1);
            8'h08: return m_data[31:0];
            8'h0C: return {16'd0, m_fc};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] a, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @0x%02h: got 0x%08h expected 0x%08h", nm, a, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (PSEL && PENABLE && !PWRITE) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read @0x%02h: got 1 read expected 0", PADDR[7:0]);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("prdata",    e.addr, PRDATA,           e.rd);
                chk("pslverr",   e.addr, 32'(PSLVERR),     32'(e.err));
                chk("frame_irq", e.addr, 32'(frame_irq),   32'(e.irq));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    task automatic apb_read(input logic [7:0] a);
        exp_t e;
        e.addr = a;
        e.rd   = exp_rd(a);
        e.err  = !(a inside {8'h00, 8'h04, 8'h08, 8'h0C});
        e.irq  = m_irq_en & (m_done | m_timeout);
        sb.push_back(e);
        PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = {24'd0, a};
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PADDR = 0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input bit with_bit);
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = {24'd0, a}; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1;
        if (with_bit) begin bit_valid = 1; bit_data = 1; end
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0;
        bit_valid = 0; bit_data = 0;
        if (a == 8'h00) begin
            m_irq_en = d[1];
            if (d[0]) begin m_mode = 1; m_q.delete(); end
        end else if (a == 8'h04) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_timeout = 0;
            if (d[3]) m_overrun = 0;
        end
    endtask

    task automatic send_bit(input bit b);
        bit_valid = 1; bit_data = b;
        @(posedge PCLK); #1 bit_valid = 0; bit_data = 0;
        model_bit(b);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            send_bit(w[31-i]);
            idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic read_all();
        apb_read(8'h04); apb_read(8'h08); apb_read(8'h0C); apb_read(8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        bit          ie;
        int          kind;
        model_reset();
        idle(3);
        PRESERN = 1;
        idle(1);
        read_all();

        // Full frame with interrupt enabled
        apb_write(8'h00, 32'h3, 0);
        send_bits(32'hA5A5_0F0F, 32, 0);
        read_all();

        // Extra bit after completion flags overrun
        send_bit(1);
        apb_read(8'h04); apb_read(8'h08);
        apb_write(8'h04, 32'hE, 0);
        apb_read(8'h04);

        // Partial frame then idle until timeout
        apb_write(8'h00, 32'h3, 0);
        send_bits(32'hF800_0000, 5, 2);
        idle(c_TO + 5);
        model_timeout();
        apb_read(8'h04); apb_read(8'h08);
        apb_write(8'h04, 32'h4, 0);
        apb_read(8'h04);

        // Bad offset, then arm colliding with a bit
        apb_read(8'h10);
        apb_write(8'h10, 32'hFFFF_FFFF, 0);
        apb_read(8'h04);
        apb_write(8'h00, 32'h1, 1);
        apb_read(8'h04);
        idle(c_TO + 5);
        model_timeout();
        apb_read(8'h04);
        apb_write(8'h04, 32'hE, 0);

        for (int it = 0; it < 40; it++) begin
            ie   = 1'($urandom);
            kind = $urandom_range(0, 9);
            w    = $urandom;
            apb_write(8'h00, {30'd0, ie, 1'b1}, 0);
            if (kind == 6) begin
                send_bits(w, $urandom_range(0, 31), 3);
                idle(c_TO + 5);
                model_timeout();
            end else begin
                if (kind == 7) begin
                    send_bits(~w, $urandom_range(1, 31), 3);
                    apb_write(8'h00, {30'd0, ie, 1'b1}, 0);
                end
                send_bits(w, 32, 3);
                if (kind == 8) send_bit(1'($urandom));
            end
            read_all();
            apb_write(8'h04, $urandom & 32'hF, 0);
            apb_read(8'h04);
        end

        // Frame counter wrap
        apb_write(8'h04, 32'hE, 0);
        force dut.r_frame_count = 16'hFFFF;
        idle(1);
        release dut.r_frame_count;
        m_fc = 16'hFFFF;
        apb_read(8'h0C);
        apb_write(8'h00, 32'h1, 0);
        send_bits($urandom, 32, 1);
        apb_read(8'h0C); apb_read(8'h08);

        // Reset mid-frame, then unarmed bits are ignored
        apb_write(8'h00, 32'h3, 0);
        send_bits($urandom, 20, 1);
        PRESERN = 0;
        model_reset();
        idle(1);
        apb_read(8'h04); apb_read(8'h08);
        PRESERN = 1;
        idle(1);
        send_bits($urandom, 32, 1);
        read_all();

        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
